// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    localparam int NDIG_DEF = 8;
    localparam int DIV_DEF  = 50000;
    localparam int GAP_DEF  = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_e;

    // Active-high {a,b,c,d,e,f,g,dp} codes, entry i encodes hex digit i.
    localparam logic [15:0][7:0] SEG_CODES = {
        8'h8E, 8'hDE, 8'h7A, 8'h1A, 8'h3E, 8'hEE, 8'hE6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

endpackage

// File: rtl/hex_decode.sv
// Combinational hex digit + decimal point to active-high segment code.
module hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       dot_i,
    output logic [7:0] code_o
);

    // Table lookup, dot lands in bit 0 (dp).
    always_comb begin
        code_o = SEG_CODES[val_i] | {7'b0, dot_i};
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Round-robin seven-segment scan controller with per-digit registers,
// a blanking gap at the start of every slot and a tear-free write port.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NDIG = NDIG_DEF,
    parameter int DIV  = DIV_DEF,
    parameter int GAP  = GAP_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [2:0]      wr_addr,
    input  logic [3:0]      wr_data,
    input  logic            wr_dot,
    input  logic            wr_en,
    output logic [7:0]      seg,
    output logic [NDIG-1:0] an,
    output logic            frame_tick
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_W = $clog2(DIV);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NDIG-1:0][3:0]   val_q;
    logic [NDIG-1:0]        dot_q, en_q;
    logic [7:0]             seg_q, seg_d;
    logic [NDIG-1:0]        an_q, an_d;
    logic                   ft_q, ft_d;

    logic                   slot_end, wr_in_range, wr_fire;
    logic [IDX_W-1:0]       wr_idx;
    logic [7:0]             code;

    assign slot_end    = (cnt_q == CNT_W'(DIV - 1));
    assign wr_in_range = (32'(wr_addr) < NDIG);
    assign wr_idx      = wr_addr[IDX_W-1:0];

    // Hold off writes to the digit that is currently lit; others always pass.
    assign wr_ready = !((state_q == SHOW) && (32'(wr_addr) == 32'(idx_q)));
    assign wr_fire  = wr_valid && wr_ready && wr_in_range;

    hex_decode u_dec (
        .val_i  (val_q[idx_q]),
        .dot_i  (dot_q[idx_q]),
        .code_o (code)
    );

    // Digit register file; out-of-range addresses are accepted and dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
            dot_q <= '0;
            en_q  <= '0;
        end else if (wr_fire) begin
            val_q[wr_idx] <= wr_data;
            dot_q[wr_idx] <= wr_dot;
            en_q[wr_idx]  <= wr_en;
        end
    end

    // Scan state, counters and registered pin drivers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= '1;
            ft_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            ft_q    <= ft_d;
        end
    end

    // Next-state: BLANK for the first GAP cycles of a slot, SHOW for the rest.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        ft_d    = 1'b0;
        seg_d   = 8'hFF;
        an_d    = '1;
        if (slot_end) begin
            cnt_d   = '0;
            state_d = BLANK;
            if (idx_q == IDX_W'(NDIG - 1)) begin
                idx_d = '0;
                ft_d  = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else if (cnt_q == CNT_W'(GAP - 1)) begin
            state_d = SHOW;
        end
        if ((state_q == SHOW) && en_q[idx_q]) begin
            seg_d        = ~code;
            an_d[idx_q]  = 1'b0;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a 4-digit and a 1-digit instance checked every
// cycle against a slot-arithmetic model, plus directed pattern checks.
module tb_seg_scan_ctrl;

    localparam int NA = 4, DA = 16, GA = 4, FA = NA * DA;
    localparam int NB = 1, DB = 8,  GB = 2, FB = NB * DB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    logic wr_valid, wr_ready, wr_dot, wr_en, frame_tick;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] seg;
    logic [NA-1:0] an;

    logic b_valid, b_ready, b_dot, b_en, b_ft;
    logic [2:0] b_addr;
    logic [3:0] b_data;
    logic [7:0] b_seg;
    logic [NB-1:0] b_an;

    seg_scan_ctrl #(.NDIG(NA), .DIV(DA), .GAP(GA)) u_a (
        .clk(clk), .rst_n(rst_a), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_dot(wr_dot), .wr_en(wr_en),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    seg_scan_ctrl #(.NDIG(NB), .DIV(DB), .GAP(GB)) u_b (
        .clk(clk), .rst_n(rst_b), .wr_valid(b_valid), .wr_ready(b_ready),
        .wr_addr(b_addr), .wr_data(b_data), .wr_dot(b_dot), .wr_en(b_en),
        .seg(b_seg), .an(b_an), .frame_tick(b_ft)
    );

    int n_chk = 0, n_fail = 0;
    int ta = 0, tb = 0;
    logic [3:0] mva [NA];
    logic       mda [NA];
    logic       mea [NA];
    logic [3:0] mvb = '0;
    logic       mdb = 1'b0, meb = 1'b0;
    bit skip_a = 0, drop_b = 1, acc_a_dut = 0;
    int ft_a_cnt = 0, ft_b_cnt = 0, fall_b = 0;
    logic an_b_prev = 1'b1;
    int s;

    function automatic logic [7:0] code_of(input logic [3:0] v);
        case (v)
            4'h0: return 8'hFC; 4'h1: return 8'h60; 4'h2: return 8'hDA; 4'h3: return 8'hF2;
            4'h4: return 8'h66; 4'h5: return 8'hB6; 4'h6: return 8'hBE; 4'h7: return 8'hE0;
            4'h8: return 8'hFE; 4'h9: return 8'hE6; 4'hA: return 8'hEE; 4'hB: return 8'h3E;
            4'hC: return 8'h1A; 4'hD: return 8'h7A; 4'hE: return 8'hDE; default: return 8'h8E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_a();
        for (int i = 0; i < NA; i++) begin
            mva[i] = '0; mda[i] = 1'b0; mea[i] = 1'b0;
        end
    endtask

    // One clock: predict from elapsed-cycle arithmetic, then compare.
    task automatic cyc();
        logic ra, rb, acca, accb, efa, efb, eab;
        logic [7:0] esa, esb;
        logic [3:0] eaa;
        int d;
        ra = 1'b1; rb = 1'b1; acca = 1'b0; accb = 1'b0; efa = 1'b0; efb = 1'b0;
        eab = 1'b1; esa = 8'hFF; esb = 8'hFF; eaa = 4'hF;
        @(negedge clk);
        if (!skip_a) begin
            d  = (ta / DA) % NA;
            ra = !(((ta % DA) >= GA) && (int'(wr_addr) == d));
            chk("rdy_a", 32'(wr_ready), 32'(ra));
            acca = wr_valid && ra;
            acc_a_dut = wr_valid && wr_ready;
            if (((ta % DA) >= GA) && mea[d]) begin
                esa = ~(code_of(mva[d]) | {7'b0, mda[d]});
                eaa = ~(4'b0001 << d);
            end
            efa = ((ta % FA) == FA - 1);
        end
        rb = !(((tb % DB) >= GB) && (b_addr == 3'd0));
        chk("rdy_b", 32'(b_ready), 32'(rb));
        accb = b_valid && rb;
        if (((tb % DB) >= GB) && meb) begin
            esb = ~(code_of(mvb) | {7'b0, mdb});
            eab = 1'b0;
        end
        efb = ((tb % FB) == FB - 1);
        @(posedge clk); #1;
        if (!skip_a) begin
            chk("seg_a", 32'(seg), 32'(esa));
            chk("an_a", 32'(an), 32'(eaa));
            chk("ft_a", 32'(frame_tick), 32'(efa));
            if (frame_tick) ft_a_cnt++;
            ta++;
            if (acca && wr_addr < NA) begin
                mva[wr_addr[1:0]] = wr_data;
                mda[wr_addr[1:0]] = wr_dot;
                mea[wr_addr[1:0]] = wr_en;
            end
        end
        chk("seg_b", 32'(b_seg), 32'(esb));
        chk("an_b", 32'(b_an), 32'(eab));
        chk("ft_b", 32'(b_ft), 32'(efb));
        if (b_ft) ft_b_cnt++;
        if (an_b_prev && !b_an[0]) fall_b++;
        an_b_prev = b_an[0];
        tb++;
        if (accb && b_addr == 3'd0) begin
            mvb = b_data; mdb = b_dot; meb = b_en;
        end
        if (accb && drop_b) b_valid = 1'b0;
    endtask

    task automatic wr_a(input logic [2:0] a, input logic [3:0] v, input logic dt,
                        input logic en_i, output int stalls);
        bit got;
        got = 0; stalls = 0;
        wr_addr = a; wr_data = v; wr_dot = dt; wr_en = en_i; wr_valid = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            if (acc_a_dut) got = 1; else stalls++;
        end
        wr_valid = 1'b0;
        chk("wr_a_accept", 32'(got), 32'd1);
    endtask

    task automatic run_to(input int phase);
        for (int i = 0; i < FA; i++) begin
            if ((ta % FA) == phase) break;
            cyc();
        end
    endtask

    initial begin
        clear_a();
        rst_a = 1'b0; rst_b = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_dot = 1'b0; wr_en = 1'b0;
        b_valid = 1'b1; b_addr = 3'd0; b_data = 4'h7; b_dot = 1'b1; b_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg_a", 32'(seg), 32'hFF);
        chk("rst_an_a", 32'(an), 32'hF);
        chk("rst_ft_a", 32'(frame_tick), 32'd0);
        chk("rst_rdy_a", 32'(wr_ready), 32'd1);
        chk("rst_seg_b", 32'(b_seg), 32'hFF);
        chk("rst_an_b", 32'(b_an), 32'd1);
        rst_a = 1'b1; rst_b = 1'b1;

        // Three idle frames on A; B gets one enabled digit at the first edge.
        repeat (3 * FA) cyc();
        chk("ft_a_3frames", 32'(ft_a_cnt), 32'd3);
        chk("ft_b_count", 32'(ft_b_cnt), 32'(3 * FA / DB));
        chk("an_b_falls", 32'(fall_b), 32'(3 * FA / DB));

        // Digits 0 and 1.
        wr_a(3'd0, 4'h1, 1'b0, 1'b1, s);
        wr_a(3'd1, 4'h8, 1'b1, 1'b1, s);
        run_to(10);
        chk("dig0_an", 32'(an), 32'hE);
        chk("dig0_seg", 32'(seg), 32'h9F);
        run_to(17);
        chk("gap_an", 32'(an), 32'hF);
        chk("gap_seg", 32'(seg), 32'hFF);
        run_to(26);
        chk("dig1_an", 32'(an), 32'hD);
        chk("dig1_seg", 32'(seg), 32'h00);

        // Write to the lit digit 2 stalls until slot 3 begins.
        run_to(38);
        wr_a(3'd2, 4'hB, 1'b0, 1'b1, s);
        chk("stall_dig2", 32'(s), 32'd10);
        run_to(42);
        chk("dig2_an", 32'(an), 32'hB);
        chk("dig2_seg", 32'(seg), 32'hC1);

        // Enable then disable digit 3; out-of-range address is harmless.
        wr_a(3'd3, 4'h5, 1'b0, 1'b1, s);
        run_to(58);
        chk("dig3_on_an", 32'(an), 32'h7);
        chk("dig3_on_seg", 32'(seg), 32'h49);
        wr_a(3'd3, 4'h5, 1'b0, 1'b0, s);
        run_to(58);
        chk("dig3_off_an", 32'(an), 32'hF);
        chk("dig3_off_seg", 32'(seg), 32'hFF);
        wr_a(3'd6, 4'hE, 1'b1, 1'b1, s);
        chk("stall_addr6", 32'(s), 32'd0);
        repeat (FA) cyc();

        // Random writes on both instances.
        drop_b = 0;
        for (int i = 0; i < 600; i++) begin
            wr_valid = ($urandom_range(0, 3) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            wr_data  = 4'($urandom);
            wr_dot   = 1'($urandom);
            wr_en    = ($urandom_range(0, 3) != 0);
            b_valid  = ($urandom_range(0, 3) == 0);
            b_addr   = 3'($urandom_range(0, 2));
            b_data   = 4'($urandom);
            b_dot    = 1'($urandom);
            b_en     = 1'($urandom);
            cyc();
        end
        wr_valid = 1'b0; b_valid = 1'b0;

        // Asynchronous reset in the middle of digit 2's lit window.
        run_to(40);
        #2 rst_a = 1'b0;
        #1;
        chk("mid_rst_seg", 32'(seg), 32'hFF);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_ft", 32'(frame_tick), 32'd0);
        chk("mid_rst_rdy", 32'(wr_ready), 32'd1);
        skip_a = 1;
        repeat (2) cyc();
        rst_a = 1'b1;
        skip_a = 0;
        ta = 0;
        clear_a();
        wr_a(3'd0, 4'h3, 1'b0, 1'b1, s);
        chk("post_rst_stall", 32'(s), 32'd0);
        repeat (GA - 1) cyc();
        chk("post_rst_blank", 32'(an), 32'hF);
        cyc();
        chk("post_rst_an", 32'(an), 32'hE);
        chk("post_rst_seg", 32'(seg), 32'h0D);
        repeat (FA) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
